// File: rtl/image_fetch_streamer.sv
// Reads one image record from the image ROM and streams its pixel words to the
// first MLP layer over valid/ready, capturing the trailing label word separately.
module image_fetch_streamer #(
    parameter int numImages    = 1797,
    parameter int imageSize    = 65,
    parameter int addressWidth = 17,
    parameter int dataWidth    = 16,
    parameter int indexWidth   = 11,
    parameter int fifoDepth    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [indexWidth-1:0]   img_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rom_ren,
    output logic [addressWidth-1:0] rom_radd,
    input  logic [dataWidth-1:0]    rom_data,
    output logic [dataWidth-1:0]    pix_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_last,
    output logic [dataWidth-1:0]    label,
    output logic                    label_valid
);
    // Handshake: a pixel moves when pix_valid && pix_ready on a rising edge;
    // pix_valid never drops and pix_data never changes until that happens.

    localparam int CntW = $clog2(imageSize + 1);
    localparam int PtrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
    localparam int OccW = $clog2(fifoDepth + 1) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, FETCH, DRAIN} state_t;

    state_t                  state, state_next;
    logic [indexWidth-1:0]   idx_q;
    logic [addressWidth-1:0] base;
    logic [CntW-1:0]         rd_cnt;
    logic                    inflight, inflight_last, inflight_label;
    logic [dataWidth-1:0]    mem_data [fifoDepth];
    logic                    mem_last [fifoDepth];
    logic [PtrW-1:0]         wr_ptr, rd_ptr;
    logic [OccW-1:0]         fifo_count;
    logic [dataWidth-1:0]    label_q;
    logic                    label_valid_q;
    logic                    err_q;

    logic start_ok, issue_ok, push, pop, drain_ok;

    always_comb begin
        start_ok = start && ({1'b0, img_idx} < (indexWidth + 1)'(numImages));
        // Credit check on registered occupancy keeps one slot free for the
        // word returning this cycle, so the FIFO can never overflow.
        issue_ok = (state == FETCH) &&
                   ((fifo_count + OccW'(inflight)) < OccW'(fifoDepth - 1));
        push     = inflight && !inflight_label;
        pix_valid = (fifo_count != '0);
        pop      = pix_valid && pix_ready;
        drain_ok = (fifo_count == '0) && !inflight && label_valid_q;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_ok) state_next = SETUP;
            SETUP: state_next = FETCH;
            FETCH: if (issue_ok && (rd_cnt == CntW'(imageSize - 1))) state_next = DRAIN;
            DRAIN: if (drain_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done        = (state == DRAIN) && drain_ok;
        busy        = (state != IDLE) && !done;
        err         = err_q;
        rom_ren     = issue_ok;
        rom_radd    = issue_ok ? (base + addressWidth'(rd_cnt)) : '0;
        pix_data    = pix_valid ? mem_data[rd_ptr] : '0;
        pix_last    = pix_valid ? mem_last[rd_ptr] : 1'b0;
        label       = label_q;
        label_valid = label_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx_q          <= '0;
            base           <= '0;
            rd_cnt         <= '0;
            inflight       <= 1'b0;
            inflight_last  <= 1'b0;
            inflight_label <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            label_q        <= '0;
            label_valid_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= (state == IDLE) && start && !start_ok;
            if ((state == IDLE) && start_ok) begin
                idx_q         <= img_idx;
                label_valid_q <= 1'b0;
            end
            if (state == SETUP) begin
                base   <= addressWidth'(idx_q) * addressWidth'(imageSize);
                rd_cnt <= '0;
            end
            if (issue_ok) rd_cnt <= rd_cnt + 1'b1;
            inflight       <= issue_ok;
            inflight_last  <= issue_ok && (rd_cnt == CntW'(imageSize - 2));
            inflight_label <= issue_ok && (rd_cnt == CntW'(imageSize - 1));
            if (inflight && inflight_label) begin
                label_q       <= rom_data;
                label_valid_q <= 1'b1;
            end
            if (push) wr_ptr <= (wr_ptr == PtrW'(fifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PtrW'(fifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rom_data;
            mem_last[wr_ptr] <= inflight_last;
        end
    end

endmodule

// File: tb/tb_image_fetch_streamer.sv
// Bench for image_fetch_streamer: ROM model holds word n = n mod 65536, and each
// image's expected pixel stream and label are computed from the record layout.
module tb_image_fetch_streamer;
    localparam int NI = 1797;
    localparam int IS = 65;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int IW = 11;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] img_idx = '0;
    logic          busy, done, err, rom_ren;
    logic [AW-1:0] rom_radd;
    logic [DW-1:0] rom_data = '0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          pix_last;
    logic [DW-1:0] label;
    logic          label_valid;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [DW:0] exp_q[$];

    image_fetch_streamer #(
        .numImages(NI), .imageSize(IS), .addressWidth(AW),
        .dataWidth(DW), .indexWidth(IW), .fifoDepth(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .img_idx(img_idx),
        .busy(busy), .done(done), .err(err),
        .rom_ren(rom_ren), .rom_radd(rom_radd), .rom_data(rom_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .label(label), .label_valid(label_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM with one cycle of read latency.
    always @(posedge clk) if (rom_ren) rom_data <= rom_radd[DW-1:0];

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, err, rom_ren, pix_valid, pix_last, label_valid} !== 7'b0 ||
            rom_radd !== '0 || pix_data !== '0 || label !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b ren=%0b radd=%0d pv=%0b pd=%0d pl=%0b lab=%0d lv=%0b, all required 0",
                     busy, done, err, rom_ren, rom_radd, pix_valid, pix_data, pix_last, label, label_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // mode 0: ready always high with exact timing; 1: 10-cycle stall at pixel 10
    // then random; 2: random ready. inject pulses a start with image 5 mid-stream.
    task automatic stream_image(input int idx, input int mode, input bit inject);
        int base, issued, hs, outst, stall_cnt;
        bit seen_done, prev_stall;
        logic [DW-1:0] prev_data, exp_label;
        logic [31:0] w;
        logic [DW:0] e;
        base = idx * IS;
        issued = 0; hs = 0; outst = 0; stall_cnt = 0;
        seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
        w = base + IS - 1;
        exp_label = w[DW-1:0];
        exp_q.delete();
        for (int k = 0; k < IS - 1; k++) begin
            w = base + k;
            exp_q.push_back({(k == IS - 2), w[DW-1:0]});
        end
        for (int c = 0; c < 1500 && !seen_done; c++) begin
            start   = (c == 0) || (inject && c == 30);
            img_idx = (c != 0 && inject) ? IW'(5) : IW'(idx);
            if (mode == 0) pix_ready = 1'b1;
            else if (mode == 1 && hs < 10) pix_ready = 1'b1;
            else if (mode == 1 && hs == 10 && stall_cnt < 10) begin
                pix_ready = 1'b0; stall_cnt++;
            end else pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (busy !== 1'b1 || label_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL accept_state img=%0d: busy=%0b label_valid=%0b, required 1/0", idx, busy, label_valid);
                end
            end
            if (mode == 0) begin
                vectors++;
                if (rom_ren !== (c >= 2 && c <= 66) || pix_valid !== (c >= 4 && c <= 67) ||
                    done !== (c == 68) || busy !== (c >= 1 && c <= 67)) begin
                    miscompares++;
                    $display("FAIL timing img=%0d cycle T+%0d: ren=%0b pv=%0b done=%0b busy=%0b, required %0b %0b %0b %0b",
                             idx, c, rom_ren, pix_valid, done, busy, (c >= 2 && c <= 66),
                             (c >= 4 && c <= 67), (c == 68), (c >= 1 && c <= 67));
                end
            end
            if (rom_ren) begin
                vectors++;
                if (rom_radd !== AW'(base + issued) || issued >= IS) begin
                    miscompares++;
                    $display("FAIL rom_addr img=%0d read %0d: got %0d, required %0d", idx, issued, rom_radd, base + issued);
                end
                if (issued < IS - 1) outst++;
                issued++;
            end
            if (prev_stall) begin
                vectors++;
                if (pix_valid !== 1'b1 || pix_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL stall_hold img=%0d: pv=%0b data=%0d, required 1 and %0d", idx, pix_valid, pix_data, prev_data);
                end
            end
            vectors++;
            if (outst > FD - 1) begin
                miscompares++;
                $display("FAIL occupancy img=%0d: %0d words buffered or in flight, limit %0d", idx, outst, FD - 1);
            end
            if (pix_valid && pix_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_pixel img=%0d: got %0d, none expected", idx, pix_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({pix_last, pix_data} !== e) begin
                        miscompares++;
                        $display("FAIL pixel img=%0d #%0d: got last=%0b data=%0d, required last=%0b data=%0d",
                                 idx, hs, pix_last, pix_data, e[DW], e[DW-1:0]);
                    end
                end
                hs++;
                outst--;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            if (done) begin
                seen_done = 1'b1;
                vectors++;
                if (label !== exp_label || label_valid !== 1'b1 || exp_q.size() != 0 || issued != IS) begin
                    miscompares++;
                    $display("FAIL completion img=%0d: label=%0d lv=%0b left=%0d reads=%0d, required %0d 1 0 %0d",
                             idx, label, label_valid, exp_q.size(), issued, exp_label, IS);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!seen_done) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout img=%0d: no done within budget, %0d pixels seen of %0d", idx, hs, IS - 1);
        end
    endtask

    task automatic test_invalid(input int idx);
        start = 1'b1; img_idx = IW'(idx);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (err !== (c == 1) || busy !== 1'b0 || rom_ren !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid_idx %0d cycle T+%0d: err=%0b busy=%0b ren=%0b done=%0b, required %0b 0 0 0",
                         idx, c, err, busy, rom_ren, done, (c == 1));
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        int hs;
        bit hit;
        hs = 0; hit = 1'b0;
        start = 1'b1; img_idx = '0; pix_ready = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                vectors++;
                if (pix_data !== DW'(hs)) begin
                    miscompares++;
                    $display("FAIL abort_pixel #%0d: got %0d, required %0d", hs, pix_data, hs);
                end
                hs++;
                if (hs == 21) hit = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!hit) begin
            vectors++; miscompares++;
            $display("FAIL abort_timeout: only %0d pixels before reset point, required 21", hs);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, err, rom_ren, pix_valid, pix_last, label_valid} !== 7'b0 ||
            rom_radd !== '0 || pix_data !== '0 || label !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: busy=%0b done=%0b err=%0b ren=%0b pv=%0b pd=%0d lab=%0d lv=%0b, all required 0",
                     busy, done, err, rom_ren, pix_valid, pix_data, label, label_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (pix_valid !== 1'b0 || busy !== 1'b0 || rom_ren !== 1'b0 || label_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet cycle %0d: pv=%0b busy=%0b ren=%0b lv=%0b, required 0", c, pix_valid, busy, rom_ren, label_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        stream_image(0, 0, 1'b0);
        stream_image(1796, 0, 1'b0);
        stream_image(0, 1, 1'b0);
        test_invalid(1797);
        test_invalid(2047);
        stream_image(0, 2, 1'b1);
        test_reset_abort();
        stream_image(3, 0, 1'b0);
        for (int i = 0; i < 4; i++) stream_image(int'($urandom_range(0, NI - 1)), 2, 1'b0);
        stream_image(42, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
